// File: rtl/mux_nto1_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux_nto1_arb                                                    |
// | Brief    : Registered N-to-1 datapath mux with valid/ready on every input  |
// |            and on the output. Fixed external select or round-robin        |
// |            arbitration among valid inputs, chosen by the mode input.       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module mux_nto1_arb #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    // Highest legal channel index; the pointer wraps here, not at 2^SEL_W.
    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             have_cand;
    logic [SEL_W-1:0] cand;
    logic [WIDTH-1:0] cand_data;
    logic             xfer;

    // Pick the candidate channel: external select, or first valid from ptr.
    always_comb begin
        int idx;
        have_cand = 1'b0;
        cand      = '0;
        idx       = 0;
        if (!mode) begin
            // Out-of-range select never matches a channel, so nothing is granted.
            cand = select;
            for (int i = 0; i < NUM_IN; i++) begin
                if (SEL_W'(i) == select && in_valid[i]) begin
                    have_cand = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                // ptr_q < NUM_IN, so a single subtraction wraps the search index.
                idx = int'(ptr_q) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!have_cand && in_valid[idx]) begin
                    have_cand = 1'b1;
                    cand      = SEL_W'(idx);
                end
            end
        end
    end

    // Drive ready to the candidate and steer its data; unselected data never leaks.
    always_comb begin
        load_en   = !out_valid_q || out_ready;
        in_ready  = '0;
        cand_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == cand) begin
                // Fixed mode offers ready on the selected channel even when it is idle.
                in_ready[i] = load_en && (mode ? have_cand : 1'b1);
                cand_data   = in_data[i*WIDTH +: WIDTH];
            end
        end
        xfer = load_en && have_cand;
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = cand_data;
                out_src_d  = cand;
            end
        end
        // Pointer only advances on round-robin grants so fixed mode leaves it parked.
        if (xfer && mode) begin
            ptr_d = (cand == c_last_idx) ? '0 : cand + SEL_W'(1);
        end
    end

    // State registers with asynchronous clear; an in-flight word is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule
`default_nettype wire
